// File: rtl/loader_pkg.sv
// loader_pkg: shared types and field widths for the program loader and the control unit.
// Provides the loader FSM state encoding and the instruction word layout {opcode, literal}.
package loader_pkg;
    localparam int OPCODE_WIDTH = 7;
    localparam int LIT_WIDTH = 8;
    localparam int WORD_WIDTH = OPCODE_WIDTH + LIT_WIDTH;
    typedef enum logic [2:0] {HDR, HI, LO, CHK, DONE, ERR} state_t;
endpackage

// File: rtl/program_loader.sv
// program_loader: byte-serial boot loader that writes a framed, XOR-checked program into instruction memory.
// Ports: clk/reset (sync, active-high); in_data/in_valid/in_ready byte stream;
// im_we/im_addr/im_wdata instruction memory write port; cpu_hold/done/error status; word_count words written.
import loader_pkg::*;

module program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [WORD_WIDTH-1:0] im_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);
    state_t                  state, nxt;
    logic [ADDR_WIDTH-1:0]   remaining, addr;
    logic [7:0]              checksum;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        nxt = state;
        if (accept) begin
            case (state)
                HDR:     nxt = HI;
                HI:      nxt = in_data[7] ? ERR : LO;
                LO:      nxt = (remaining == '0) ? CHK : HI;
                CHK:     nxt = (in_data == checksum) ? DONE : ERR;
                default: nxt = state;
            endcase
        end
    end

    // Status outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HDR;
            remaining  <= '0;
            addr       <= '0;
            checksum   <= '0;
            opcode     <= '0;
            word_count <= '0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            in_ready   <= 1'b1;
        end else begin
            state    <= nxt;
            im_we    <= accept && state == LO;
            in_ready <= nxt != DONE && nxt != ERR;
            done     <= nxt == DONE;
            error    <= nxt == ERR;
            cpu_hold <= nxt != DONE;
            if (accept) begin
                case (state)
                    HDR: begin
                        remaining <= ADDR_WIDTH'(in_data);
                        checksum  <= checksum ^ in_data;
                    end
                    HI: begin
                        // A rejected opcode byte is not folded into the checksum.
                        if (!in_data[7]) begin
                            opcode   <= in_data[OPCODE_WIDTH-1:0];
                            checksum <= checksum ^ in_data;
                        end
                    end
                    LO: begin
                        checksum   <= checksum ^ in_data;
                        im_addr    <= addr;
                        im_wdata   <= {opcode, in_data};
                        // addr wraps to 0 after word 256, but LO is left for CHK then.
                        addr       <= addr + ADDR_WIDTH'(1);
                        word_count <= word_count + (ADDR_WIDTH+1)'(1);
                        if (remaining != '0) remaining <= remaining - ADDR_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized scoreboard bench for program_loader against a frame-level reference model.
module tb_program_loader;
    import loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, im_we, cpu_hold, done, error;
    logic [7:0]  im_addr;
    logic [14:0] im_wdata;
    logic [8:0]  word_count;

    program_loader #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int d;} wr_t;
    wr_t        exp_q[$];
    logic [7:0] frm[$];
    int         checks = 0, errors = 0, nwrites = 0;
    logic       prev_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the next expected write.
    always @(negedge clk) begin
        if (im_we) begin
            nwrites++;
            chk("we_single_cycle", {31'b0, prev_we}, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h", im_addr, im_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("im_addr", {24'b0, im_addr}, e.a);
                chk("im_wdata", {17'b0, im_wdata}, e.d);
            end
        end
        prev_we <= im_we;
    end

    task automatic check_reset();
        chk("rst_im_we", {31'b0, im_we}, 0);
        chk("rst_im_addr", {24'b0, im_addr}, 0);
        chk("rst_im_wdata", {17'b0, im_wdata}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_error", {31'b0, error}, 0);
        chk("rst_cpu_hold", {31'b0, cpu_hold}, 1);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_word_count", {23'b0, word_count}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset();
    endtask

    // Reference model: walks the frame by its byte layout and predicts writes and outcome.
    task automatic model_frame(output int acc, output int st, output int nw);
        int n;
        logic [7:0] x, hi, lo;
        n = int'(frm[0]) + 1;
        x = frm[0];
        acc = 1; st = 0; nw = 0;
        for (int i = 0; i < n; i++) begin
            hi = frm[1 + 2*i];
            acc++;
            if (hi[7]) begin
                st = 2;
                return;
            end
            lo = frm[2 + 2*i];
            acc++;
            x = x ^ hi ^ lo;
            exp_q.push_back('{i, int'(hi[6:0]) * 256 + int'(lo)});
            nw++;
        end
        acc++;
        st = (frm[2*n + 1] == x) ? 1 : 2;
    endtask

    task automatic run_frame(input int gmode, output int accepted);
        int gap;
        accepted = 0;
        foreach (frm[i]) begin
            if (!in_ready) break;
            in_data = frm[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            accepted++;
            gap = gmode >= 0 ? gmode : int'($urandom_range(0, 3));
            repeat (gap) begin @(posedge clk); #1; end
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_frame(input int gmode);
        int acc_e, st_e, nw_e, acc, w0;
        model_frame(acc_e, st_e, nw_e);
        w0 = nwrites;
        run_frame(gmode, acc);
        chk("accepted", acc, acc_e);
        chk("write_count", nwrites - w0, nw_e);
        chk("pending_writes", exp_q.size(), 0);
        chk("done", {31'b0, done}, st_e == 1);
        chk("error", {31'b0, error}, st_e == 2);
        chk("cpu_hold", {31'b0, cpu_hold}, st_e != 1);
        chk("in_ready", {31'b0, in_ready}, 0);
        chk("word_count", {23'b0, word_count}, nw_e);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] x, b;
        int n, bad;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset();

        frm = '{8'h01, 8'h0A, 8'h05, 8'h12, 8'h03, 8'h1F};
        check_frame(0);

        do_reset();
        frm = '{8'h01, 8'h0A, 8'h05, 8'h12, 8'h03, 8'h1E};
        check_frame(0);

        do_reset();
        frm = '{8'h00, 8'h80, 8'h05, 8'h06};
        check_frame(0);

        do_reset();
        frm = '{8'h01, 8'h0A, 8'h05, 8'h12, 8'h03, 8'h1F};
        check_frame(3);

        do_reset();
        frm = '{8'hFF};
        x = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            frm.push_back({1'b0, b[6:0]});
            frm.push_back(b);
            x = x ^ {1'b0, b[6:0]} ^ b;
        end
        frm.push_back(x);
        check_frame(0);

        // Reset after the first word of a 3-word frame, then load a fresh frame.
        do_reset();
        exp_q.push_back('{0, 'h0102});
        foreach (frm[i]) frm.delete();
        frm = '{8'h02, 8'h01, 8'h02};
        foreach (frm[i]) begin
            in_data = frm[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset();
        chk("mid_reset_write", exp_q.size(), 0);
        exp_q.delete();
        frm = '{8'h00, 8'h01, 8'h02, 8'h03};
        check_frame(0);

        for (int f = 0; f < 20; f++) begin
            do_reset();
            n = int'($urandom_range(1, 12));
            bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            frm = '{8'(n - 1)};
            x = 8'(n - 1);
            for (int i = 0; i < n; i++) begin
                b = {(i == bad), 7'($urandom)};
                frm.push_back(b);
                x ^= b;
                b = 8'($urandom);
                frm.push_back(b);
                x ^= b;
            end
            if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            frm.push_back(x);
            check_frame(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
